pipe_wb: RTL and testbench

- Write-back stage of the five-stage MIPS pipeline.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and waits for the data-memory read response on loads.
- Aligns and extends byte/half/word load data, then drives the register-file write port (wd, rf_wena, wa) that the decode stage consumes.
- Also gates writes on arithmetic overflow, writes to $0 and misaligned loads.

---
 rtl/pipe_wb_pkg.sv | 19 +
 rtl/load_align.sv | 37 +++
 rtl/pipe_wb.sv | 119 +++++++++++
 tb/tb_pipe_wb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_wb_pkg.sv
// rtl/pipe_wb_pkg.sv - shared state encoding, widths and load lane constants for write-back
package pipe_wb_pkg;
   localparam int DW     = 32;
   localparam int AW     = 5;
   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;
   localparam logic       HALF_HI = 1'b1;

   typedef enum logic [1:0] {
      WB_IDLE    = 2'd0,
      WB_WAIT_LD = 2'd1,
      WB_WRITE   = 2'd2
   } wb_state_e;
endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed byte/half/word lane and extends it
module load_align
   import pipe_wb_pkg::*;
(
   input  logic [DW-1:0] rdata_i,
   input  logic [1:0]    addr_i,
   input  logic          w_i,
   input  logic          h_i,
   input  logic          b_i,
   input  logic          z_i,
   output logic [DW-1:0] data_o,
   output logic          aligned_o
);
   logic [BYTE_W-1:0] byte_v;
   logic [HALF_W-1:0] half_v;

   always_comb begin
      case (addr_i)
         LANE_B1: byte_v = rdata_i[15:8];
         LANE_B2: byte_v = rdata_i[23:16];
         LANE_B3: byte_v = rdata_i[31:24];
         default: byte_v = rdata_i[7:0];
      endcase
      half_v = (addr_i[1] == HALF_HI) ? rdata_i[31:16] : rdata_i[15:0];

      // Word is the fallback when no width bit is set.
      data_o    = rdata_i;
      aligned_o = (addr_i == LANE_B0);
      if (!w_i && h_i) begin
         data_o    = {{(DW-HALF_W){half_v[HALF_W-1] & ~z_i}}, half_v};
         aligned_o = ~addr_i[0];
      end else if (!w_i && b_i) begin
         data_o    = {{(DW-BYTE_W){byte_v[BYTE_W-1] & ~z_i}}, byte_v};
         aligned_o = 1'b1;
      end
   end
endmodule

// File: rtl/pipe_wb.sv
// rtl/pipe_wb.sv - MIPS write-back stage: waits for load data, aligns it, drives the regfile port
module pipe_wb #(
   parameter int DW    = pipe_wb_pkg::DW,
   parameter int AW    = pipe_wb_pkg::AW,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m_valid,
   output logic             m_ready,
   input  logic             m_wrf,
   input  logic [AW-1:0]    m_wa,
   input  logic [DW-1:0]    m_alu,
   input  logic             m_overflow,
   input  logic             m_load,
   input  logic             m_w,
   input  logic             m_h,
   input  logic             m_b,
   input  logic             m_z,
   input  logic             dmem_rvalid,
   input  logic [DW-1:0]    dmem_rdata,
   output logic [DW-1:0]    wd,
   output logic             rf_wena,
   output logic [AW-1:0]    wa,
   output logic             misalign,
   output logic [CNT_W-1:0] retire_cnt
);
   import pipe_wb_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   wb_state_e        state_q;
   logic             ld_wrf_q;
   logic [AW-1:0]    ld_wa_q;
   logic [1:0]       ld_addr_q;
   logic             ld_w_q, ld_h_q, ld_b_q, ld_z_q;
   logic [DW-1:0]    wd_q;
   logic [AW-1:0]    wa_q;
   logic             rf_wena_q, misalign_q;
   logic [CNT_W-1:0] retire_q;
   logic [DW-1:0]    al_data;
   logic             al_ok;
   logic             accept;

   assign m_ready    = (state_q != WB_WAIT_LD);
   assign accept     = m_valid && m_ready;
   assign wd         = wd_q;
   assign wa         = wa_q;
   assign rf_wena    = rf_wena_q;
   assign misalign   = misalign_q;
   assign retire_cnt = retire_q;

   load_align u_align (
      .rdata_i   (dmem_rdata),
      .addr_i    (ld_addr_q),
      .w_i       (ld_w_q),
      .h_i       (ld_h_q),
      .b_i       (ld_b_q),
      .z_i       (ld_z_q),
      .data_o    (al_data),
      .aligned_o (al_ok)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WB_IDLE;
         ld_wrf_q   <= 1'b0;
         ld_wa_q    <= '0;
         ld_addr_q  <= '0;
         ld_w_q     <= 1'b0;
         ld_h_q     <= 1'b0;
         ld_b_q     <= 1'b0;
         ld_z_q     <= 1'b0;
         wd_q       <= '0;
         wa_q       <= '0;
         rf_wena_q  <= 1'b0;
         misalign_q <= 1'b0;
         retire_q   <= '0;
      end else begin
         rf_wena_q  <= 1'b0;
         misalign_q <= 1'b0;
         case (state_q)
            WB_WAIT_LD: begin
               if (dmem_rvalid) begin
                  wd_q       <= al_data;
                  wa_q       <= ld_wa_q;
                  rf_wena_q  <= ld_wrf_q && (ld_wa_q != '0) && al_ok;
                  misalign_q <= ~al_ok;
                  retire_q   <= retire_q + CNT_ONE;
                  state_q    <= WB_WRITE;
               end
            end
            default: begin
               // IDLE and WRITE accept identically, giving 1/cycle for non-loads.
               if (accept) begin
                  ld_wrf_q  <= m_wrf;
                  ld_wa_q   <= m_wa;
                  ld_addr_q <= m_alu[1:0];
                  ld_w_q    <= m_w;
                  ld_h_q    <= m_h;
                  ld_b_q    <= m_b;
                  ld_z_q    <= m_z;
                  if (m_load) begin
                     state_q <= WB_WAIT_LD;
                  end else begin
                     wd_q      <= m_alu;
                     wa_q      <= m_wa;
                     rf_wena_q <= m_wrf && !m_overflow && (m_wa != '0);
                     retire_q  <= retire_q + CNT_ONE;
                     state_q   <= WB_WRITE;
                  end
               end else begin
                  state_q <= WB_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_wb.sv
// tb/tb_pipe_wb.sv - scoreboard bench for the write-back stage
module tb_pipe_wb;
   logic        clk = 1'b0;
   logic        rst;
   logic        m_valid, m_ready, m_wrf, m_overflow, m_load, m_w, m_h, m_b, m_z;
   logic [4:0]  m_wa;
   logic [31:0] m_alu;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [31:0] wd;
   logic        rf_wena;
   logic [4:0]  wa;
   logic        misalign;
   logic [31:0] retire_cnt;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        we;
      logic        mis;
      logic        chk_wd;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        mon_en = 1'b0;
   logic        rst_prev = 1'b1;
   logic [31:0] prev_cnt = '0;
   logic [31:0] cnt0;

   pipe_wb #(.DW(32), .AW(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_wrf(m_wrf),
      .m_wa(m_wa), .m_alu(m_alu), .m_overflow(m_overflow), .m_load(m_load),
      .m_w(m_w), .m_h(m_h), .m_b(m_b), .m_z(m_z), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .wd(wd), .rf_wena(rf_wena), .wa(wa),
      .misalign(misalign), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] ld_model(input logic [31:0] rd, input logic [1:0] a,
                                            input logic w, input logic h, input logic b,
                                            input logic z);
      logic [31:0] s;
      logic [31:0] d;
      logic        ok;
      if (w || (!h && !b)) begin
         ok = (a == 2'b00);
         d  = rd;
      end else if (h) begin
         ok = !a[0];
         s  = rd >> {a[1], 4'b0000};
         d  = z ? (s & 32'h0000_FFFF) : {{16{s[15]}}, s[15:0]};
      end else begin
         ok = 1'b1;
         s  = rd >> {a, 3'b000};
         d  = z ? (s & 32'h0000_00FF) : {{24{s[7]}}, s[7:0]};
      end
      return {ok, d};
   endfunction

   always @(negedge clk) begin
      if (rst_prev || !mon_en) begin
         prev_cnt = retire_cnt;
      end else if (retire_cnt != prev_cnt) begin
         chk("cnt_step", retire_cnt, prev_cnt + 32'd1);
         chk("sb_pending", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rf_wena", rf_wena, e.we);
            chk("misalign", misalign, e.mis);
            chk("wa", wa, e.wa);
            if (e.chk_wd) chk("wd", wd, e.wd);
         end
         prev_cnt = retire_cnt;
      end else begin
         chk("idle_wena", rf_wena, 0);
         chk("idle_misalign", misalign, 0);
      end
      rst_prev = rst;
   end

   task automatic wait_ready();
      for (int k = 0; k < 20 && !m_ready; k++) begin
         @(posedge clk); #1;
      end
      chk("accept_ready", m_ready, 1);
   endtask

   task automatic idle_cycle();
      m_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_alu(input logic [4:0] a_wa, input logic [31:0] alu,
                           input logic wrf, input logic ovf);
      exp_t x;
      m_valid = 1'b1; m_load = 1'b0; m_wa = a_wa; m_alu = alu;
      m_wrf = wrf; m_overflow = ovf; m_w = 1'b1; m_h = 1'b0; m_b = 1'b0; m_z = 1'b0;
      wait_ready();
      x.wa = a_wa; x.wd = alu; x.we = wrf && !ovf && (a_wa != 5'd0);
      x.mis = 1'b0; x.chk_wd = 1'b1;
      sb.push_back(x);
      @(posedge clk); #1;
   endtask

   task automatic send_load(input logic [4:0] a_wa, input logic [31:0] addr,
                            input logic w, input logic h, input logic b, input logic z,
                            input logic ovf, input logic [31:0] rd, input int lat,
                            input logic junk);
      exp_t        x;
      logic [32:0] r;
      m_valid = 1'b1; m_load = 1'b1; m_wa = a_wa; m_alu = addr; m_wrf = 1'b1;
      m_overflow = ovf; m_w = w; m_h = h; m_b = b; m_z = z;
      if (junk) begin
         dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      end
      wait_ready();
      @(posedge clk); #1;
      m_valid = 1'b0; m_load = 1'b0; dmem_rvalid = 1'b0;
      for (int i = 0; i < lat; i++) begin
         chk("ld_wait_ready", m_ready, 0);
         @(posedge clk); #1;
      end
      chk("ld_resp_ready", m_ready, 0);
      r = ld_model(rd, addr[1:0], w, h, b, z);
      x.wa = a_wa; x.wd = r[31:0]; x.we = r[32] && (a_wa != 5'd0);
      x.mis = !r[32]; x.chk_wd = r[32];
      sb.push_back(x);
      dmem_rvalid = 1'b1; dmem_rdata = rd;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0; dmem_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; m_valid = 1'b0; m_wrf = 1'b0; m_wa = '0; m_alu = '0; m_overflow = 1'b0;
      m_load = 1'b0; m_w = 1'b0; m_h = 1'b0; m_b = 1'b0; m_z = 1'b0;
      dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_wd", wd, 0);
      chk("rst_wa", wa, 0);
      chk("rst_wena", rf_wena, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_cnt", retire_cnt, 0);
      chk("rst_ready", m_ready, 1);
      mon_en = 1'b1;

      send_alu(5'd8, 32'h0000_0005, 1'b1, 1'b0);
      chk("add_wena", rf_wena, 1);
      chk("add_wa", wa, 8);
      chk("add_wd", wd, 5);
      chk("add_cnt", retire_cnt, 1);
      idle_cycle();

      send_alu(5'd9, 32'h1234_5678, 1'b1, 1'b1);
      chk("ovf_wena", rf_wena, 0);
      chk("ovf_cnt", retire_cnt, 2);
      idle_cycle();
      send_alu(5'd0, 32'h0000_00AA, 1'b1, 1'b0);
      chk("r0_wena", rf_wena, 0);
      idle_cycle();

      send_load(5'd3, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8011_2233, 3, 1'b0);
      chk("lb_wd", wd, 32'hFFFF_FF80);
      send_load(5'd4, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8011_2233, 3, 1'b0);
      chk("lbu_wd", wd, 32'h0000_0080);
      send_load(5'd5, 32'h2000_0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7FFE_0000, 1, 1'b0);
      send_load(5'd6, 32'h2000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7FFE_0000, 0, 1'b0);
      chk("lh_mis_pulse", misalign, 1);
      chk("lh_mis_wena", rf_wena, 0);
      idle_cycle();
      send_load(5'd7, 32'h3000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 0, 1'b1);
      send_load(5'd11, 32'h3000_0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 2, 1'b0);
      send_load(5'd12, 32'h3000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE, 1, 1'b1);
      send_load(5'd13, 32'h3000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_A5C3, 2, 1'b0);
      send_load(5'd0, 32'h3000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA, 0, 1'b0);
      idle_cycle();

      cnt0 = retire_cnt;
      for (int i = 0; i < 4; i++) begin
         send_alu(5'(16 + i), 32'hA000_0000 + 32'(i * 7), 1'b1, 1'b0);
         chk("b2b_ready", m_ready, 1);
         chk("b2b_wena", rf_wena, 1);
      end
      idle_cycle();
      chk("b2b_cnt", retire_cnt, cnt0 + 32'd4);

      m_valid = 1'b1; m_load = 1'b1; m_wa = 5'd20; m_alu = 32'h4000_0000;
      m_wrf = 1'b1; m_w = 1'b1; m_h = 1'b0; m_b = 1'b0; m_z = 1'b0; m_overflow = 1'b0;
      @(posedge clk); #1;
      m_valid = 1'b0; m_load = 1'b0;
      chk("rstld_wait", m_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstld_ready", m_ready, 1);
      chk("rstld_cnt", retire_cnt, 0);
      chk("rstld_wena", rf_wena, 0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      chk("late_wena", rf_wena, 0);
      chk("late_cnt", retire_cnt, 0);
      chk("late_wd", wd, 0);
      chk("late_ready", m_ready, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
